// File: rtl/lcd_phy_param_if.sv
// Handshake between the LCD transaction layer (master) and lcd_phy_param (slave).
// Carries the request strobes, the byte/RS to write and the phy status flags.
interface lcd_phy_param_if;
  logic       do_init;
  logic       do_send_data;
  logic [7:0] data_to_send;
  logic       lcdrs_in;
  logic       init_done;
  logic       send_data_done;
  logic       busy;

  modport master (
    output do_init, do_send_data, data_to_send, lcdrs_in,
    input  init_done, send_data_done, busy
  );

  modport slave (
    input  do_init, do_send_data, data_to_send, lcdrs_in,
    output init_done, send_data_done, busy
  );
endinterface

// File: rtl/lcd_phy_param.sv
// HD44780-style write-only LCD phy (4- or 8-bit bus): power-on init plus byte writes.
// Define LCD_LONG_CMD_EN to give user clear/home commands (RS=0, 0x01..0x03) the long wait.
module lcd_phy_param #(
  parameter int BUS_W     = 8,
  parameter int CNT_W     = 20,
  parameter int T_AS      = 2,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int T_CMD     = 2000,
  parameter int T_LONG    = 82000,
  parameter int T_WAKE    = 205000,
  parameter int T_POWERUP = 750000
) (
  input  logic             clk,
  input  logic             reset,
  lcd_phy_param_if.slave   host,
  output logic             lcde,
  output logic             lcdrs,
  output logic             lcdrw,
  output logic [BUS_W-1:0] lcddat
);

  typedef enum logic [2:0] {IDLE, PWRUP, SETUP, EHIGH, HOLD, WAIT, DONE} state_t;

  localparam bit         NIBBLE    = (BUS_W == 4);
  localparam logic [3:0] LAST_STEP = NIBBLE ? 4'd8 : 4'd7;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       seq_idx;
  logic             in_init;
  logic [7:0]       data_q;
  logic             single_q;
  logic             low_q;
  logic [CNT_W-1:0] wait_q;

  logic [3:0]       step_idx;
  logic [7:0]       step_byte;
  logic             step_single;
  logic [CNT_W-1:0] step_wait;
  logic             long_cmd;
  logic [CNT_W-1:0] user_wait;

  function automatic logic [CNT_W-1:0] ld(input int t);
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [BUS_W-1:0] bus_val(input logic [7:0] d, input logic low);
    if (NIBBLE) return BUS_W'(low ? d[3:0] : d[7:4]);
    return BUS_W'(d);
  endfunction

  // Init ROM: in 4-bit mode the first four entries go out as a single high-nibble phase.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    if (NIBBLE) begin
      case (idx)
        4'd0, 4'd1, 4'd2: return 8'h30;
        4'd3:             return 8'h20;
        4'd4:             return 8'h28;
        4'd5:             return 8'h08;
        4'd6:             return 8'h01;
        4'd7:             return 8'h06;
        default:          return 8'h0C;
      endcase
    end
    case (idx)
      4'd0, 4'd1, 4'd2: return 8'h30;
      4'd3:             return 8'h38;
      4'd4:             return 8'h08;
      4'd5:             return 8'h01;
      4'd6:             return 8'h06;
      default:          return 8'h0C;
    endcase
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    step_idx    = (state == PWRUP) ? 4'd0 : seq_idx + 4'd1;
    step_byte   = init_byte(step_idx);
    step_single = NIBBLE && (step_idx <= 4'd3);
    if (step_idx <= 4'd2)        step_wait = ld(T_WAKE);
    else if (step_byte == 8'h01) step_wait = ld(T_LONG);
    else                         step_wait = ld(T_CMD);
  end

`ifdef LCD_LONG_CMD_EN
  assign long_cmd = !host.lcdrs_in && (host.data_to_send inside {8'h01, 8'h02, 8'h03});
`else
  assign long_cmd = 1'b0;
`endif

  assign user_wait = long_cmd ? ld(T_LONG) : ld(T_CMD);
  assign host.busy = (state != IDLE);
  assign lcdrw     = 1'b0;

  // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      seq_idx             <= '0;
      in_init             <= 1'b0;
      data_q              <= '0;
      single_q            <= 1'b0;
      low_q               <= 1'b0;
      wait_q              <= '0;
      lcde                <= 1'b0;
      lcdrs               <= 1'b0;
      lcddat              <= '0;
      host.init_done      <= 1'b0;
      host.send_data_done <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
          if (host.do_init) begin
            state          <= PWRUP;
            cnt            <= ld(T_POWERUP);
            in_init        <= 1'b1;
            seq_idx        <= '0;
            lcdrs          <= 1'b0;
            host.init_done <= 1'b0;
          end else if (host.do_send_data && host.init_done) begin
            state    <= SETUP;
            cnt      <= ld(T_AS);
            in_init  <= 1'b0;
            data_q   <= host.data_to_send;
            single_q <= 1'b0;
            low_q    <= 1'b0;
            wait_q   <= user_wait;
            lcdrs    <= host.lcdrs_in;
            lcddat   <= bus_val(host.data_to_send, 1'b0);
          end
        end
        PWRUP, WAIT: begin
          if (cnt == '0) begin
            if (state == WAIT && (!in_init || seq_idx == LAST_STEP)) begin
              state <= DONE;
              if (in_init) host.init_done      <= 1'b1;
              else         host.send_data_done <= 1'b1;
            end else begin
              state    <= SETUP;
              cnt      <= ld(T_AS);
              seq_idx  <= step_idx;
              data_q   <= step_byte;
              single_q <= step_single;
              wait_q   <= step_wait;
              low_q    <= 1'b0;
              lcdrs    <= 1'b0;
              lcddat   <= bus_val(step_byte, 1'b0);
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= EHIGH;
            cnt   <= ld(T_PW);
            lcde  <= 1'b1;
          end
        end
        EHIGH: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= ld(T_H);
            lcde  <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (NIBBLE && !low_q && !single_q) begin
              state  <= SETUP;
              cnt    <= ld(T_AS);
              low_q  <= 1'b1;
              lcddat <= bus_val(data_q, 1'b1);
            end else begin
              state <= WAIT;
              cnt   <= wait_q;
            end
          end
        end
        DONE: begin
          state               <= IDLE;
          in_init             <= 1'b0;
          host.send_data_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_phy_param.sv
// Bench for lcd_phy_param: an 8-bit and a 4-bit instance driven in lockstep, E pulses and
// done strobes captured by monitors and compared against a write-list timing model.
module tb_lcd_phy_param;
  localparam int T_AS = 1, T_PW = 2, T_H = 1, T_CMD = 5, T_LONG = 20, T_WAKE = 8, T_POWERUP = 10;

  typedef struct { logic [7:0] dat; logic rs; int rise; int fall; logic [7:0] dat_fall; } ev_t;
  typedef struct { logic [7:0] b; logic rs; logic single; int wt; } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       do_init, do_send;
  logic [7:0] data_d;
  logic       rs_d;

  lcd_phy_param_if if8();
  lcd_phy_param_if if4();
  assign if8.do_init = do_init;  assign if8.do_send_data = do_send;
  assign if8.data_to_send = data_d;  assign if8.lcdrs_in = rs_d;
  assign if4.do_init = do_init;  assign if4.do_send_data = do_send;
  assign if4.data_to_send = data_d;  assign if4.lcdrs_in = rs_d;

  logic       lcde8, lcdrs8, lcdrw8, lcde4, lcdrs4, lcdrw4;
  logic [7:0] lcddat8;
  logic [3:0] lcddat4;

  lcd_phy_param #(.BUS_W(8), .CNT_W(20), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_CMD(T_CMD),
    .T_LONG(T_LONG), .T_WAKE(T_WAKE), .T_POWERUP(T_POWERUP)) dut8 (
    .clk(clk), .reset(reset), .host(if8),
    .lcde(lcde8), .lcdrs(lcdrs8), .lcdrw(lcdrw8), .lcddat(lcddat8));

  lcd_phy_param #(.BUS_W(4), .CNT_W(20), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_CMD(T_CMD),
    .T_LONG(T_LONG), .T_WAKE(T_WAKE), .T_POWERUP(T_POWERUP)) dut4 (
    .clk(clk), .reset(reset), .host(if4),
    .lcde(lcde4), .lcdrs(lcdrs4), .lcdrw(lcdrw4), .lcddat(lcddat4));

  logic [1:0] busy_v, idone_v;
  assign busy_v  = {if4.busy, if8.busy};
  assign idone_v = {if4.init_done, if8.init_done};

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  ev_t  ev_q[2][$];
  int   done_q[2][$];
  int   init_rise[2];
  logic e_prev[2], idn_prev[2];
  ev_t  exp_q[2][$];
  wr_t  plan[2][$];
  int   exp_end[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon(input int d, input logic e, input logic [7:0] dat, input logic rs,
                     input logic dn, input logic idn);
    ev_t ev;
    if (e && !e_prev[d]) begin
      ev.dat = dat; ev.rs = rs; ev.rise = cyc; ev.fall = -1; ev.dat_fall = '0;
      ev_q[d].push_back(ev);
    end
    if (!e && e_prev[d] && ev_q[d].size() > 0) begin
      ev = ev_q[d].pop_back();
      ev.fall = cyc; ev.dat_fall = dat;
      ev_q[d].push_back(ev);
    end
    if (dn) done_q[d].push_back(cyc);
    if (idn && !idn_prev[d]) init_rise[d] = cyc;
    e_prev[d]   = e;
    idn_prev[d] = idn;
  endtask

  always @(negedge clk) begin
    mon(0, lcde8, lcddat8, lcdrs8, if8.send_data_done, if8.init_done);
    mon(1, lcde4, {4'h0, lcddat4}, lcdrs4, if4.send_data_done, if4.init_done);
  end

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      ev_q[d].delete(); done_q[d].delete(); init_rise[d] = -1;
    end
  endtask

  // Reference model: a list of writes turned into E pulse times; d=1 is the 4-bit bus.
  task automatic build_model(input int d, input int start);
    int t;
    t = start;
    exp_q[d].delete();
    foreach (plan[d][i]) begin
      logic [7:0] b;
      int phases;
      ev_t e;
      b = plan[d][i].b;
      phases = (d == 1 && !plan[d][i].single) ? 2 : 1;
      for (int p = 0; p < phases; p++) begin
        e.dat = (d == 0) ? b : ((p == 0) ? {4'h0, b[7:4]} : {4'h0, b[3:0]});
        e.rs = plan[d][i].rs;
        e.rise = t + T_AS;
        e.fall = e.rise + T_PW;
        e.dat_fall = e.dat;
        exp_q[d].push_back(e);
        t += T_AS + T_PW + T_H;
      end
      t += plan[d][i].wt;
    end
    exp_end[d] = t;
  endtask

  task automatic plan_init(input int d);
    plan[d].delete();
    repeat (3) plan[d].push_back('{8'h30, 1'b0, 1'b1, T_WAKE});
    if (d == 1) plan[d].push_back('{8'h20, 1'b0, 1'b1, T_CMD});
    plan[d].push_back('{(d == 0) ? 8'h38 : 8'h28, 1'b0, 1'b0, T_CMD});
    plan[d].push_back('{8'h08, 1'b0, 1'b0, T_CMD});
    plan[d].push_back('{8'h01, 1'b0, 1'b0, T_LONG});
    plan[d].push_back('{8'h06, 1'b0, 1'b0, T_CMD});
    plan[d].push_back('{8'h0C, 1'b0, 1'b0, T_CMD});
  endtask

  function automatic int user_wait(input logic [7:0] b, input logic r);
`ifdef LCD_LONG_CMD_EN
    if (!r && b >= 8'h01 && b <= 8'h03) return T_LONG;
`endif
    return T_CMD;
  endfunction

  task automatic test_reset();
    reset = 1'b1; do_init = 1'b0; do_send = 1'b0; data_d = '0; rs_d = 1'b0;
    e_prev = '{1'b0, 1'b0}; idn_prev = '{1'b0, 1'b0};
    clear_mon();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({lcde8, lcdrs8, lcdrw8, lcddat8, if8.init_done, if8.send_data_done, if8.busy} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_w8: got %b expected all zero",
               {lcde8, lcdrs8, lcdrw8, lcddat8, if8.init_done, if8.send_data_done, if8.busy});
    end
    n_cmp++;
    if ({lcde4, lcdrs4, lcdrw4, lcddat4, if4.init_done, if4.send_data_done, if4.busy} !== 10'h0) begin
      n_err++;
      $display("FAIL reset_w4: got %b expected all zero",
               {lcde4, lcdrs4, lcdrw4, lcddat4, if4.init_done, if4.send_data_done, if4.busy});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_send_before_init();
    clear_mon();
    do_send = 1'b1; data_d = 8'h41; rs_d = 1'b1;
    @(negedge clk);
    do_send = 1'b0;
    repeat (30) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ev_q[d].size() !== 0) begin
        n_err++; $display("FAIL early_send_pulses w%0d: got %0d expected 0", d, ev_q[d].size());
      end
      n_cmp++;
      if (done_q[d].size() !== 0 || busy_v[d] !== 1'b0) begin
        n_err++;
        $display("FAIL early_send_state w%0d: got done=%0d busy=%b expected 0/0", d, done_q[d].size(), busy_v[d]);
      end
    end
  endtask

  task automatic test_init(input logic with_send);
    int acc, k;
    clear_mon();
    do_init = 1'b1; do_send = with_send; data_d = 8'h41; rs_d = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    do_init = 1'b0; do_send = 1'b0;
    for (int d = 0; d < 2; d++) begin plan_init(d); build_model(d, acc + T_POWERUP); end
    k = 0;
    while ((init_rise[0] < 0 || init_rise[1] < 0) && k < 400) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (init_rise[d] !== exp_end[d]) begin
        n_err++; $display("FAIL init_done_rise w%0d: got cycle %0d expected %0d", d, init_rise[d], exp_end[d]);
      end
      n_cmp++;
      if (ev_q[d].size() !== exp_q[d].size()) begin
        n_err++; $display("FAIL init_pulse_count w%0d: got %0d expected %0d", d, ev_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < ev_q[d].size() && i < exp_q[d].size(); i++) begin
        n_cmp++;
        if ({ev_q[d][i].dat, ev_q[d][i].rs, ev_q[d][i].rise, ev_q[d][i].fall, ev_q[d][i].dat_fall} !==
            {exp_q[d][i].dat, exp_q[d][i].rs, exp_q[d][i].rise, exp_q[d][i].fall, exp_q[d][i].dat_fall}) begin
          n_err++;
          $display("FAIL init_pulse w%0d #%0d: got dat=%h rs=%b rise=%0d fall=%0d hold=%h expected dat=%h rs=%b rise=%0d fall=%0d hold=%h",
                   d, i, ev_q[d][i].dat, ev_q[d][i].rs, ev_q[d][i].rise, ev_q[d][i].fall, ev_q[d][i].dat_fall,
                   exp_q[d][i].dat, exp_q[d][i].rs, exp_q[d][i].rise, exp_q[d][i].fall, exp_q[d][i].dat_fall);
        end
      end
      n_cmp++;
      if (done_q[d].size() !== 0 || busy_v[d] !== 1'b0 || idone_v[d] !== 1'b1) begin
        n_err++;
        $display("FAIL init_end_state w%0d: got done=%0d busy=%b init_done=%b expected 0/0/1",
                 d, done_q[d].size(), busy_v[d], idone_v[d]);
      end
    end
  endtask

  task automatic test_send(input logic [7:0] b, input logic r, input logic poke);
    int acc, k;
    clear_mon();
    do_send = 1'b1; data_d = b; rs_d = r;
    acc = cyc + 1;
    @(negedge clk);
    do_send = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk);
      do_send = 1'b1; do_init = 1'b1; data_d = ~b; rs_d = ~r;
      @(negedge clk);
      do_send = 1'b0; do_init = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      plan[d].delete();
      plan[d].push_back('{b, r, 1'b0, user_wait(b, r)});
      build_model(d, acc);
    end
    k = 0;
    while ((done_q[0].size() == 0 || done_q[1].size() == 0) && k < 100) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (done_q[d].size() !== 1 || (done_q[d].size() > 0 && done_q[d][0] !== exp_end[d])) begin
        n_err++;
        $display("FAIL send_done w%0d data=%h rs=%b: got %0d pulses first at %0d expected 1 pulse at %0d",
                 d, b, r, done_q[d].size(), (done_q[d].size() > 0) ? done_q[d][0] : -1, exp_end[d]);
      end
      n_cmp++;
      if (ev_q[d].size() !== exp_q[d].size()) begin
        n_err++; $display("FAIL send_pulse_count w%0d: got %0d expected %0d", d, ev_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < ev_q[d].size() && i < exp_q[d].size(); i++) begin
        n_cmp++;
        if ({ev_q[d][i].dat, ev_q[d][i].rs, ev_q[d][i].rise, ev_q[d][i].fall, ev_q[d][i].dat_fall} !==
            {exp_q[d][i].dat, exp_q[d][i].rs, exp_q[d][i].rise, exp_q[d][i].fall, exp_q[d][i].dat_fall}) begin
          n_err++;
          $display("FAIL send_pulse w%0d #%0d: got dat=%h rs=%b rise=%0d fall=%0d hold=%h expected dat=%h rs=%b rise=%0d fall=%0d hold=%h",
                   d, i, ev_q[d][i].dat, ev_q[d][i].rs, ev_q[d][i].rise, ev_q[d][i].fall, ev_q[d][i].dat_fall,
                   exp_q[d][i].dat, exp_q[d][i].rs, exp_q[d][i].rise, exp_q[d][i].fall, exp_q[d][i].dat_fall);
        end
      end
      n_cmp++;
      if (busy_v[d] !== 1'b0 || idone_v[d] !== 1'b1) begin
        n_err++; $display("FAIL send_end_state w%0d: got busy=%b init_done=%b expected 0/1", d, busy_v[d], idone_v[d]);
      end
    end
  endtask

  task automatic test_long_cmd();
    test_send(8'h01, 1'b0, 1'b0);
    test_send(8'h02, 1'b0, 1'b0);
    test_send(8'h03, 1'b0, 1'b0);
    test_send(8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_random_send();
    repeat (6) test_send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_back_to_back();
    test_send(8'h41, 1'b1, 1'b1);
    test_send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    test_send(8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    test_init(1'b1);
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    do_send = 1'b1; data_d = 8'h55; rs_d = 1'b1;
    @(negedge clk);
    do_send = 1'b0;
    k = 0;
    while (lcde8 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (lcde8 !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ehigh: got lcde=%b expected 1 before reset", lcde8);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({lcde8, lcde4, idone_v, busy_v} !== 6'h0) begin
      n_err++;
      $display("FAIL reset_mid_async: got lcde=%b%b init_done=%b busy=%b expected all zero",
               lcde8, lcde4, idone_v, busy_v);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (30) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ev_q[d].size() !== 0 || done_q[d].size() !== 0 || init_rise[d] !== -1) begin
        n_err++;
        $display("FAIL reset_mid_quiet w%0d: got pulses=%0d done=%0d init_rise=%0d expected 0/0/-1",
                 d, ev_q[d].size(), done_q[d].size(), init_rise[d]);
      end
    end
    test_init(1'b0);
  endtask

  initial begin
    test_reset();
    test_send_before_init();
    test_init(1'b0);
    test_send(8'h41, 1'b1, 1'b0);
    test_long_cmd();
    test_random_send();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
